// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 1-to-8 serial deserializer.
package demux_pkg;

  localparam int N  = 8;
  localparam int SW = 3;

  localparam logic [N-1:0] ALL_SLOTS = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

endpackage

// File: rtl/demux1to8_dec.sv
// Combinational one-hot slot decoder: routes a single write enable to slot sel.
module demux1to8_dec
  import demux_pkg::*;
(
  input  logic          en,
  input  logic [SW-1:0] sel,
  output logic [N-1:0]  we
);

  assign we = {{(N-1){1'b0}}, en} << sel;

endmodule

// File: rtl/demux1to8_deser.sv
// Serial-to-parallel collector: steers incoming bits into eight slots and hands
// the completed byte to the consumer with a valid/ready handshake.
module demux1to8_deser
  import demux_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          addr_mode,
  input  logic [SW-1:0] s,
  input  logic          flush,
  output logic [N-1:0]  q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  slot_mask
);

  state_e        state_q;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          mode_q;
  logic [N-1:0]  buf_q, buf_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [N-1:0]  q_q;
  logic          out_valid_q;
  logic          din_ready_q;

  logic          accept;
  logic          mode_cur;
  logic [SW-1:0] sel;
  logic [N-1:0]  we;

  // The first bit of a byte uses addr_mode directly since mode_q latches on that same edge.
  always_comb begin
    accept   = din_valid & din_ready_q & ~flush;
    mode_cur = (state_q == IDLE) ? addr_mode : mode_q;
    sel      = mode_cur ? s : ptr_q;
    buf_d    = (buf_q & ~we) | ({N{din}} & we);
    mask_d   = mask_q | we;
    ptr_d    = ptr_q + {{(SW-1){1'b0}}, ~mode_cur};
  end

  demux1to8_dec u_dec (
    .en  (accept),
    .sel (sel),
    .we  (we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      mode_q      <= 1'b0;
      buf_q       <= '0;
      mask_q      <= '0;
      q_q         <= '0;
      out_valid_q <= 1'b0;
      din_ready_q <= 1'b1;
    end else if (flush) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      mode_q      <= 1'b0;
      buf_q       <= '0;
      mask_q      <= '0;
      q_q         <= '0;
      out_valid_q <= 1'b0;
      din_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE, FILL: begin
          if (accept) begin
            buf_q  <= buf_d;
            mask_q <= mask_d;
            ptr_q  <= ptr_d;
            if (state_q == IDLE) mode_q <= addr_mode;
            if (mask_d == ALL_SLOTS) begin
              state_q     <= FULL;
              q_q         <= buf_d;
              out_valid_q <= 1'b1;
              din_ready_q <= 1'b0;
            end else begin
              state_q <= FILL;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            mode_q      <= 1'b0;
            buf_q       <= '0;
            mask_q      <= '0;
            q_q         <= '0;
            out_valid_q <= 1'b0;
            din_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          din_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign q         = q_q;
  assign out_valid = out_valid_q;
  assign din_ready = din_ready_q;
  assign slot_mask = mask_q;

endmodule

// File: tb/tb_demux1to8_deser.sv
// Randomized and directed bench for demux1to8_deser against a slot-array reference model.
module tb_demux1to8_deser;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       addr_mode;
  logic [2:0] s;
  logic       flush;
  logic [7:0] q;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] slot_mask;

  int testCount = 0;
  int failCount = 0;

  // Reference model: a byte under construction seen as eight slots plus a "held" flag.
  bit mBits[8];
  bit mWritten[8];
  bit mHeld;
  bit mMode;
  int mNext;

  demux1to8_deser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .addr_mode (addr_mode),
    .s         (s),
    .flush     (flush),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .slot_mask (slot_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelClear();
    for (int i = 0; i < 8; i++) begin
      mBits[i]    = 1'b0;
      mWritten[i] = 1'b0;
    end
    mHeld = 1'b0;
    mMode = 1'b0;
    mNext = 0;
  endfunction

  function automatic int writtenCount();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(mWritten[i]);
    return c;
  endfunction

  function automatic logic [7:0] packWritten();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = mWritten[i];
    return v;
  endfunction

  function automatic logic [7:0] packBits();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = mBits[i];
    return v;
  endfunction

  function automatic void modelStep(input bit b, input bit dv, input bit am, input int sel,
                                    input bit fl, input bit ordy);
    int slot;
    if (fl) begin
      modelClear();
    end else if (mHeld) begin
      if (ordy) modelClear();
    end else if (dv) begin
      if (writtenCount() == 0) mMode = am;
      if (mMode) begin
        slot = sel;
      end else begin
        slot  = mNext;
        mNext = (mNext + 1) % 8;
      end
      mBits[slot]    = b;
      mWritten[slot] = 1'b1;
      if (writtenCount() == 8) mHeld = 1'b1;
    end
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, ".q"},         q,                 mHeld ? packBits() : 8'h00);
    checkOutput({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, mHeld});
    checkOutput({tag, ".din_ready"}, {7'b0, din_ready}, {7'b0, ~mHeld});
    checkOutput({tag, ".slot_mask"}, slot_mask,         packWritten());
  endtask

  // Drive one cycle of inputs, advance the model, then check just after the edge.
  task automatic applyStimulus(input string tag, input bit b, input bit dv, input bit am,
                               input int sel, input bit fl, input bit ordy);
    din       = b;
    din_valid = dv;
    addr_mode = am;
    s         = 3'(sel);
    flush     = fl;
    out_ready = ordy;
    modelStep(b, dv, am, sel, fl, ordy);
    @(posedge clk);
    #1;
    compareAll(tag);
  endtask

  task automatic autoByte(input string tag, input logic [7:0] value);
    for (int i = 0; i < 8; i++) applyStimulus(tag, value[i], 1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] pattern;
    int         addrSeq[9];
    bit         addrBit[9];
    din = 0; din_valid = 0; addr_mode = 0; s = 0; flush = 0; out_ready = 0;
    rst_n = 1'b0;
    modelClear();
    repeat (3) @(posedge clk);
    #1;
    compareAll("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Auto fill: bits 1,0,1,1,0,0,1,0 into slots 0..7.
    pattern = 8'b0100_1101;
    autoByte("autofill", pattern);
    checkOutput("autofill.q_const", q, 8'h4D);
    applyStimulus("autohold", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus("autohold", 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    drain("autodrain");
    checkOutput("autodrain.q_const", q, 8'h00);

    // Addressed fill with a rewrite of slot 3.
    addrSeq = '{7, 0, 3, 3, 1, 2, 4, 5, 6};
    addrBit = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      applyStimulus("addrfill", addrBit[i], 1'b1, 1'b1, addrSeq[i], 1'b0, 1'b0);
      if (i == 2) checkOutput("addrfill.mask89", slot_mask, 8'h89);
      if (i == 7) checkOutput("addrfill.notyet", {7'b0, out_valid}, 8'h00);
    end
    checkOutput("addrfill.q_const", q, 8'h81);
    drain("addrdrain");

    // Mode latched: first bit in auto mode, remaining bits request addressed mode at slot 7.
    applyStimulus("modelatch", 1'b1, 1'b1, 1'b0, 7, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) applyStimulus("modelatch", i[0], 1'b1, 1'b1, 7, 1'b0, 1'b0);
    checkOutput("modelatch.q_const", q, 8'hAB);
    drain("modedrain");

    // Flush on the 5th auto bit drops it; the following byte starts at slot 0.
    for (int i = 0; i < 4; i++) applyStimulus("flush", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    checkOutput("flush.mask0", slot_mask, 8'h00);
    autoByte("postflush", 8'h3C);
    checkOutput("postflush.q_const", q, 8'h3C);
    // Flush while FULL discards the held byte.
    applyStimulus("flushfull", 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    // Back-pressure: din_valid stays high while FULL, nothing is taken.
    autoByte("bp", 8'h96);
    for (int i = 0; i < 3; i++) applyStimulus("bp.hold", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus("bp.handshake", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    applyStimulus("bp.first", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("bp.slot0", slot_mask, 8'h01);
    applyStimulus("bp.flush", 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    // Asynchronous reset while four slots are filled.
    for (int i = 0; i < 4; i++) applyStimulus("midreset", 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    checkOutput("midreset.mask0F", slot_mask, 8'h0F);
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelClear();
    compareAll("midreset.async");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus("random",
                    1'($urandom_range(1)),
                    $urandom_range(99) < 70,
                    $urandom_range(99) < 40,
                    int'($urandom_range(7)),
                    $urandom_range(99) < 3,
                    $urandom_range(99) < 35);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/demux1to8_deser.md
# demux1to8_deser

Serial-to-parallel collector that reverses the 8:1 selection path. It routes single incoming bits into one of eight register slots. Slots are addressed either by an internal auto-incrementing pointer or by an explicit 3-bit select. The block presents the assembled byte with a valid/ready handshake. It sits at the receive end of any link driven by an 8:1 mux serializer.

## Interface
- N, 8, number of slots; fixed at 8 in this revision
- SW, 3, select width, log2(N)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  1  serial data bit
- din_valid  input  1  din is presented this cycle
- din_ready  output  1  block can accept a bit this cycle
- addr_mode  input  1  0 = auto pointer, 1 = slot chosen by s; sampled on the first accepted bit of each byte
- s  input  3  slot select, used only in addressed mode
- flush  input  1  synchronous abort of the byte in progress
- q  output  8  assembled byte; q[k] = bit written to slot k
- out_valid  output  1  q holds a complete byte
- out_ready  input  1  consumer takes q
- slot_mask  output  8  slots written so far in the current byte

## Operation
- Accept condition: din_valid & din_ready.
- States:
  - IDLE: no slot written; din_ready=1.
  - FILL: at least one slot written; din_ready=1.
  - FULL: out_valid=1, din_ready=0.
- IDLE→FILL: on the first accept. addr_mode is latched into mode_r at this accept; mode_r holds until the byte completes or is flushed.
- Auto mode: the bit goes to slot ptr, then ptr increments. ptr is 3 bits and resets to 0 at the start of every byte.
- Addressed mode: the bit goes to slot s. Rewriting a slot already in slot_mask overwrites its data bit; slot_mask is unchanged.
- FILL→FULL: on the accept that makes slot_mask == 8'hFF. In auto mode this is the 8th accept.
- FULL→IDLE: on out_valid & out_ready. slot_mask, ptr and the data buffer all clear to 0. q is also cleared (q=0 whenever out_valid=0).
- flush: has priority over accept. It forces IDLE and clears slot_mask, ptr and the buffer.
  - A bit presented in the same cycle is dropped.
  - flush in FULL discards the held byte; out_valid drops on the next cycle.
- No-accept cycles (din_valid=0) hold all state.

## Timing
- Reset values: q=0, out_valid=0, slot_mask=0, din_ready=1, state IDLE, ptr=0, mode_r=0.
- Deassertion of rst_n takes effect at the next clock edge; an accept is possible on the first edge after release.
- Latency: the completing bit is accepted at edge k; out_valid=1 and q are valid after edge k (visible in cycle k+1).
- Throughput: one bit per cycle while not FULL.
- FULL persists at least one cycle. The earliest next accept is the cycle after the out_ready handshake edge, so the best case is 9 cycles per byte.
- din_ready and out_valid are registered state decodes, with no combinational path from din_valid or out_ready.
- slot_mask updates on the same edge as the data write.

## Structure
- Shared package demux_pkg holds:
  - N and SW;
  - the state enum, encoded IDLE=2'd0, FILL=2'd1, FULL=2'd2;
  - the constant ALL_SLOTS = 8'hFF.
- Sub-module demux1to8_dec: combinational 1-to-8 one-hot decoder.
  - Inputs: en, sel[2:0].
  - Output: we[7:0] = en << sel.
  - It is instantiated once. sel is driven by ptr or s according to mode_r.
- Top level holds the FSM, ptr, mode_r, the data buffer, slot_mask and the output registers.

## Test plan
- Auto fill: addr_mode=0, bits 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready=0 → after the 8th edge out_valid=1, q=8'h4D, din_ready=0; it holds until out_ready=1, then returns to IDLE with q=0.
- Addressed fill with rewrite: addr_mode=1, writes (s,din) = (7,1), (0,1), (3,1), (3,0), then slots 1,2,4,5,6 with 0 → FULL after the 9th accept (slot 3 was written twice), q=8'h81; slot_mask reads 8'h89 after the 3rd write.
- Mode latched: start auto with one bit, then toggle addr_mode mid-byte → placement still follows ptr; completes after 8 accepts.
- Flush: flush asserted in the same cycle as the 5th auto bit → that bit is dropped, IDLE, slot_mask=0; the next 8 bits form a fresh byte starting at slot 0.
- Back-pressure: din_valid held high through FULL for 3 cycles → no bit is accepted; the first post-handshake accept lands in slot 0.
- Reset mid-operation: rst_n low asynchronously while in FILL with slot_mask=8'h0F → outputs go to reset values immediately, without waiting for a clock edge.
